// File: rtl/adder_chunked_nb.sv
`default_nettype none
// ============================================================================
//  Module      : adder_chunked_nb
//  Description : Multi-cycle chunked ripple adder/subtractor. Adds CHUNK bits
//                per clock, LSB chunk first, with a 1-bit inter-chunk carry.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_chunked_nb #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_NCH = WIDTH / CHUNK;
    localparam int c_IW  = (c_NCH > 1) ? $clog2(c_NCH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_carry;
    logic [c_IW-1:0]   r_idx;

    logic [31:0]       w_base;
    logic [CHUNK-1:0]  w_ca;
    logic [CHUNK-1:0]  w_cb;
    logic [CHUNK:0]    w_csum;
    logic              w_msb_cin;
    logic              w_last;

    assign w_base = 32'(r_idx) * 32'(CHUNK);
    assign w_ca   = r_a[w_base +: CHUNK];
    assign w_cb   = r_b[w_base +: CHUNK];
    assign w_csum = {1'b0, w_ca} + {1'b0, w_cb} + {{CHUNK{1'b0}}, r_carry};
    assign w_last = (r_idx == c_IW'(c_NCH - 1));

    // Carry into the top bit recovered from the sum bit and its two addends.
    assign w_msb_cin = w_csum[CHUNK-1] ^ w_ca[CHUNK-1] ^ w_cb[CHUNK-1];

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_RUN;
            S_RUN:   if (w_last)   w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        // Subtraction folds into addition: A + ~B + 1.
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{sub}};
                        r_carry <= sub | cin;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    sum[w_base +: CHUNK] <= w_csum[CHUNK-1:0];
                    r_carry              <= w_csum[CHUNK];
                    r_idx                <= r_idx + c_IW'(1);
                    if (w_last) begin
                        cout <= w_csum[CHUNK];
                        ovf  <= w_msb_cin ^ w_csum[CHUNK];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_chunked_nb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_chunked_nb
//  Description : Directed and randomised checks of adder_chunked_nb in
//                CHUNK=4, CHUNK=16 and CHUNK=1 builds sharing one stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_chunked_nb;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_ready;

    logic        ir4, ov4, co4, of4;
    logic [15:0] s4;
    logic        ir16, ov16, co16, of16;
    logic [15:0] s16;
    logic        ir1, ov1, co1, of1;
    logic [15:0] s1;

    int n_checks;
    int n_fail;

    adder_chunked_nb #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov4), .out_ready(out_ready),
        .sum(s4), .cout(co4), .ovf(of4)
    );

    adder_chunked_nb #(.WIDTH(16), .CHUNK(16)) u_full (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov16), .out_ready(out_ready),
        .sum(s16), .cout(co16), .ovf(of16)
    );

    adder_chunked_nb #(.WIDTH(16), .CHUNK(1)) u_bit (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov1), .out_ready(out_ready),
        .sum(s1), .cout(co1), .ovf(of1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operation into all three builds and waits until every build
    // shows out_valid; latencies are counted in edges after the accept edge.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tc, input logic ts,
                         output int l4, output int l16, output int l1,
                         output bit ir_seen, output bit tout);
        int n;
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        l4 = -1; l16 = -1; l1 = -1; ir_seen = 1'b0; n = 0;
        while (!(ov4 && ov16 && ov1) && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ir4) ir_seen = 1'b1;
            if (ov4  && l4  < 0) l4  = n;
            if (ov16 && l16 < 0) l16 = n;
            if (ov1  && l1  < 0) l1  = n;
        end
        tout = !(ov4 && ov16 && ov1);
    endtask

    task automatic release_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (ir4 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", ir4); end
        n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", ov4); end
        n_checks++; if ({co4, of4, s4} !== 18'h0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", {co4, of4, s4}); end
        rst = 1'b0;
    endtask

    task automatic test_add_basic();
        int l4, l16, l1; bit irs, tout;
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, l4, l16, l1, irs, tout);
        n_checks++; if (tout !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b expected 0", tout); end
        n_checks++; if ({co4, of4, s4} !== {1'b1, 1'b0, 16'h0000}) begin n_fail++; $display("FAIL basic_result: got %h expected %h", {co4, of4, s4}, {1'b1, 1'b0, 16'h0000}); end
        n_checks++; if (l4 !== 4) begin n_fail++; $display("FAIL basic_latency4: got %0d expected 4", l4); end
        n_checks++; if (l16 !== 1) begin n_fail++; $display("FAIL basic_latency16: got %0d expected 1", l16); end
        n_checks++; if (l1 !== 16) begin n_fail++; $display("FAIL basic_latency1: got %0d expected 16", l1); end
        n_checks++; if (irs !== 1'b0) begin n_fail++; $display("FAIL basic_ready_in_run: got %b expected 0", irs); end
        n_checks++; if (ir4 !== 1'b0) begin n_fail++; $display("FAIL basic_ready_in_done: got %b expected 0", ir4); end
        release_op();
    endtask

    task automatic test_overflow_and_cin();
        int l4, l16, l1; bit irs, tout;
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, l4, l16, l1, irs, tout);
        n_checks++; if ({tout, co4, of4, s4} !== {1'b0, 1'b0, 1'b1, 16'h8000}) begin n_fail++; $display("FAIL ovf_add: got %h expected %h", {tout, co4, of4, s4}, {1'b0, 1'b0, 1'b1, 16'h8000}); end
        release_op();
        do_op(16'h1234, 16'h1111, 1'b1, 1'b0, l4, l16, l1, irs, tout);
        n_checks++; if ({tout, co4, of4, s4} !== {1'b0, 1'b0, 1'b0, 16'h2346}) begin n_fail++; $display("FAIL add_cin: got %h expected %h", {tout, co4, of4, s4}, {1'b0, 1'b0, 1'b0, 16'h2346}); end
        release_op();
    endtask

    task automatic test_sub();
        int l4, l16, l1; bit irs, tout;
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, l4, l16, l1, irs, tout);
        n_checks++; if ({tout, co4, of4, s4} !== {1'b0, 1'b0, 1'b0, 16'hFFFE}) begin n_fail++; $display("FAIL sub_borrow: got %h expected %h", {tout, co4, of4, s4}, {1'b0, 1'b0, 1'b0, 16'hFFFE}); end
        release_op();
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, l4, l16, l1, irs, tout);
        n_checks++; if ({tout, co4, of4, s4} !== {1'b0, 1'b1, 1'b1, 16'h7FFF}) begin n_fail++; $display("FAIL sub_ovf: got %h expected %h", {tout, co4, of4, s4}, {1'b0, 1'b1, 1'b1, 16'h7FFF}); end
        release_op();
        do_op(16'h0007, 16'h0005, 1'b0, 1'b1, l4, l16, l1, irs, tout);
        n_checks++; if ({tout, co4, of4, s4} !== {1'b0, 1'b1, 1'b0, 16'h0002}) begin n_fail++; $display("FAIL sub_noborrow: got %h expected %h", {tout, co4, of4, s4}, {1'b0, 1'b1, 1'b0, 16'h0002}); end
        release_op();
    endtask

    task automatic test_backpressure();
        int l4, l16, l1; bit irs, tout;
        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, l4, l16, l1, irs, tout);
        n_checks++; if (tout !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: got %b expected 0", tout); end
        a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if ({ov4, ir4, co4, of4, s4} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0100}) begin
                n_fail++; $display("FAIL bp_hold_%0d: got %h expected %h", i, {ov4, ir4, co4, of4, s4}, {1'b1, 1'b0, 1'b0, 1'b0, 16'h0100});
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++; if ({ir4, ov4, s4} !== {1'b1, 1'b0, 16'h0100}) begin n_fail++; $display("FAIL bp_release: got %h expected %h", {ir4, ov4, s4}, {1'b1, 1'b0, 16'h0100}); end
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (ir4 !== 1'b1) begin n_fail++; $display("FAIL bp_ignored_valid: got %b expected 1", ir4); end
    endtask

    task automatic test_reset_in_run();
        int l4, l16, l1; bit irs, tout;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if ({ir4, ov4, co4, s4} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin n_fail++; $display("FAIL rst_run_state: got %h expected %h", {ir4, ov4, co4, s4}, {1'b1, 1'b0, 1'b0, 16'h0000}); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL rst_run_no_valid_%0d: got %b expected 0", i, ov4); end
        end
        do_op(16'h0010, 16'h0020, 1'b0, 1'b0, l4, l16, l1, irs, tout);
        n_checks++; if ({tout, co4, of4, s4} !== {1'b0, 1'b0, 1'b0, 16'h0030}) begin n_fail++; $display("FAIL rst_run_next_op: got %h expected %h", {tout, co4, of4, s4}, {1'b0, 1'b0, 1'b0, 16'h0030}); end
        n_checks++; if ({s16, s1} !== {16'h0030, 16'h0030}) begin n_fail++; $display("FAIL rst_run_next_op_builds: got %h expected %h", {s16, s1}, {16'h0030, 16'h0030}); end
        release_op();
    endtask

    task automatic test_back_to_back();
        logic [15:0] ta [4] = '{16'h00FF, 16'hABCD, 16'h0000, 16'h4000};
        logic [15:0] tb_v [4] = '{16'h0F01, 16'h5433, 16'h0001, 16'h4000};
        logic        ts [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [17:0] te [4] = '{{2'b00, 16'h1000}, {2'b10, 16'h0000}, {2'b00, 16'hFFFF}, {2'b01, 16'h8000}};
        int l4, l16, l1; bit irs, tout;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb_v[i], 1'b0, ts[i], l4, l16, l1, irs, tout);
            n_checks++;
            if ({tout, co4, of4, s4} !== {1'b0, te[i]}) begin
                n_fail++; $display("FAIL b2b_%0d: got %h expected %h", i, {tout, co4, of4, s4}, {1'b0, te[i]});
            end
            release_op();
        end
    endtask

    task automatic test_random();
        logic [15:0] ra, rb, bb;
        logic        rc, rs;
        logic [16:0] r;
        logic        eo;
        int l4, l16, l1; bit irs, tout;
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            bb = rs ? ~rb : rb;
            r  = {1'b0, ra} + {1'b0, bb} + {16'h0, (rs | rc)};
            eo = (ra[15] == bb[15]) && (r[15] != ra[15]);
            do_op(ra, rb, rc, rs, l4, l16, l1, irs, tout);
            n_checks++;
            if (tout || {co4, of4, s4} !== {r[16], eo, r[15:0]} || l4 != 4) begin
                n_fail++; $display("FAIL rand4_%0d: got %h lat %0d expected %h lat 4", i, {co4, of4, s4}, l4, {r[16], eo, r[15:0]});
            end
            n_checks++;
            if (tout || {co16, of16, s16} !== {r[16], eo, r[15:0]} || l16 != 1) begin
                n_fail++; $display("FAIL rand16_%0d: got %h lat %0d expected %h lat 1", i, {co16, of16, s16}, l16, {r[16], eo, r[15:0]});
            end
            n_checks++;
            if (tout || {co1, of1, s1} !== {r[16], eo, r[15:0]} || l1 != 16) begin
                n_fail++; $display("FAIL rand1_%0d: got %h lat %0d expected %h lat 16", i, {co1, of1, s1}, l1, {r[16], eo, r[15:0]});
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            release_op();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_add_basic();
        test_overflow_and_cin();
        test_sub();
        test_backpressure();
        test_reset_in_run();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
